// File: rtl/peripheral_bb_pkg.sv
// Shared definitions for the peripheral Wishbone arbiter slice.
//   CTI_*        : Wishbone B3 cycle type identifiers (passed through, not interpreted)
//   arb_state_t  : arbiter FSM states (ARB_ABORT is only reachable with PERIPHERAL_ARB_TIMEOUT_EN)
package peripheral_bb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY  = 2'd1,
        ARB_ABORT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/peripheral_arb_rr_bb.sv
// Combinational round-robin picker.
//   req : request vector, one bit per master
//   ptr : index of the last winner; scanning starts at ptr+1 and wraps mod NM
//   gnt : one-hot winner, 0 when no request
//   idx : winner index (0 when no request)
module peripheral_arb_rr_bb #(
    parameter int unsigned NM = 4,
    parameter int unsigned IW = $clog2(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic [NM-1:0] gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] k;
    logic          found;

    // First requester after the pointer wins; the pointer itself is checked last.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int unsigned i = 1; i <= NM; i++) begin
            k = IW'((32'(ptr) + i) % NM);
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

endmodule

// File: rtl/peripheral_arbiter_bb.sv
// Round-robin Wishbone B3 arbiter: NM masters share one slave port. The grant is
// held for the whole wb_cyc so classic and CTI/BTE bursts are never split, and
// one bus-idle cycle separates consecutive grants.
// Optional feature macro: PERIPHERAL_ARB_TIMEOUT_EN (stall timeout -> err + ABORT).
// Ports:
//   wb_clk, wb_rst           clock, asynchronous active-high reset
//   wbm_*_i                  packed master requests, master m at [m*W +: W]
//   wbm_dat/ack/err/rty_o    responses, routed only to the granted master
//   wbs_*_o                  slave-side copy of the granted master's signals
//   wbs_dat/ack/err/rty_i    slave responses
//   grant_o                  one-hot current grant, 0 when idle
module peripheral_arbiter_bb
    import peripheral_bb_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned NM      = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst,
    input  logic [NM*AW-1:0]       wbm_adr_i,
    input  logic [NM*DW-1:0]       wbm_dat_i,
    input  logic [NM*(DW/8)-1:0]   wbm_sel_i,
    input  logic [NM-1:0]          wbm_we_i,
    input  logic [NM-1:0]          wbm_cyc_i,
    input  logic [NM-1:0]          wbm_stb_i,
    input  logic [NM*3-1:0]        wbm_cti_i,
    input  logic [NM*2-1:0]        wbm_bte_i,
    output logic [NM*DW-1:0]       wbm_dat_o,
    output logic [NM-1:0]          wbm_ack_o,
    output logic [NM-1:0]          wbm_err_o,
    output logic [NM-1:0]          wbm_rty_o,
    output logic [AW-1:0]          wbs_adr_o,
    output logic [DW-1:0]          wbs_dat_o,
    output logic [DW/8-1:0]        wbs_sel_o,
    output logic                   wbs_we_o,
    output logic                   wbs_cyc_o,
    output logic                   wbs_stb_o,
    output logic [2:0]             wbs_cti_o,
    output logic [1:0]             wbs_bte_o,
    input  logic [DW-1:0]          wbs_dat_i,
    input  logic                   wbs_ack_i,
    input  logic                   wbs_err_i,
    input  logic                   wbs_rty_i,
    output logic [NM-1:0]          grant_o
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned IW = $clog2(NM);

    if (NM < 2 || NM > 16 || TIMEOUT == 0) begin : g_bad_param
        $error("peripheral_arbiter_bb: NM must be 2..16 and TIMEOUT nonzero");
    end

    arb_state_t    state, state_nxt;
    logic [NM-1:0] grant_nxt, rr_gnt, err_route;
    logic [IW-1:0] ptr, ptr_nxt, rr_idx;
    logic          busy, tmo_err;

`ifdef PERIPHERAL_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt, cnt_nxt;
    logic          slv_resp;
    assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
`endif

    assign busy = (state == ARB_BUSY);

    peripheral_arb_rr_bb #(.NM(NM), .IW(IW)) u_rr (
        .req (wbm_cyc_i),
        .ptr (ptr),
        .gnt (rr_gnt),
        .idx (rr_idx)
    );

    // State register; reset points at NM-1 so master 0 wins first.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state   <= ARB_IDLE;
            grant_o <= '0;
            ptr     <= IW'(NM - 1);
`ifdef PERIPHERAL_ARB_TIMEOUT_EN
            cnt     <= '0;
`endif
        end else begin
            state   <= state_nxt;
            grant_o <= grant_nxt;
            ptr     <= ptr_nxt;
`ifdef PERIPHERAL_ARB_TIMEOUT_EN
            cnt     <= cnt_nxt;
`endif
        end
    end

    // Next-state logic; ptr doubles as the granted index while not idle.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_o;
        ptr_nxt   = ptr;
        tmo_err   = 1'b0;
`ifdef PERIPHERAL_ARB_TIMEOUT_EN
        cnt_nxt   = cnt;
`endif
        case (state)
            ARB_IDLE: begin
                if (|wbm_cyc_i) begin
                    state_nxt = ARB_BUSY;
                    grant_nxt = rr_gnt;
                    ptr_nxt   = rr_idx;
                end
            end
            ARB_BUSY: begin
                if (!wbm_cyc_i[ptr]) begin
                    state_nxt = ARB_IDLE;
                    grant_nxt = '0;
                end
`ifdef PERIPHERAL_ARB_TIMEOUT_EN
                else if (slv_resp) begin
                    cnt_nxt = '0;
                end else if (wbs_stb_o) begin
                    if (cnt == TW'(TIMEOUT - 1)) begin
                        tmo_err   = 1'b1;
                        state_nxt = ARB_ABORT;
                    end else begin
                        cnt_nxt = cnt + TW'(1);
                    end
                end
`endif
            end
`ifdef PERIPHERAL_ARB_TIMEOUT_EN
            ARB_ABORT: begin
                if (!wbm_cyc_i[ptr]) begin
                    state_nxt = ARB_IDLE;
                    grant_nxt = '0;
                end
            end
`endif
            default: begin
                state_nxt = ARB_IDLE;
                grant_nxt = '0;
            end
        endcase
`ifdef PERIPHERAL_ARB_TIMEOUT_EN
        if (state_nxt != ARB_BUSY) cnt_nxt = '0;
`endif
    end

    // Request mux and response demux; everything is 0 with no grant, and cyc/stb and
    // responses are blocked outside BUSY.
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        wbm_dat_o = '0;
        wbm_ack_o = '0;
        err_route = '0;
        wbm_rty_o = '0;
        for (int unsigned m = 0; m < NM; m++) begin
            if (grant_o[m]) begin
                wbs_adr_o = wbm_adr_i[m*AW +: AW];
                wbs_dat_o = wbm_dat_i[m*DW +: DW];
                wbs_sel_o = wbm_sel_i[m*SW +: SW];
                wbs_we_o  = wbm_we_i[m];
                wbs_cyc_o = wbm_cyc_i[m] & busy;
                wbs_stb_o = wbm_stb_i[m] & wbm_cyc_i[m] & busy;
                wbs_cti_o = wbm_cti_i[m*3 +: 3];
                wbs_bte_o = wbm_bte_i[m*2 +: 2];
                if (busy) begin
                    wbm_dat_o[m*DW +: DW] = wbs_dat_i;
                    wbm_ack_o[m]          = wbs_ack_i;
                    err_route[m]          = wbs_err_i;
                    wbm_rty_o[m]          = wbs_rty_i;
                end
            end
        end
    end

    // Timeout error is injected toward the granted master alongside slave errors.
    assign wbm_err_o = err_route | (tmo_err ? grant_o : '0);

endmodule

// File: tb/tb_peripheral_arbiter_bb.sv
// Self-checking bench for peripheral_arbiter_bb: directed scenarios followed by random
// traffic, all checked against a transaction-level owner/pointer model.
module tb_peripheral_arbiter_bb;
    import peripheral_bb_pkg::*;

    localparam int unsigned NM = 4, DW = 32, AW = 32, SW = DW / 8, TIMEOUT = 8;

    logic                 wb_clk = 1'b0;
    logic                 wb_rst;
    logic [NM*AW-1:0]     wbm_adr_i;
    logic [NM*DW-1:0]     wbm_dat_i;
    logic [NM*SW-1:0]     wbm_sel_i;
    logic [NM-1:0]        wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [NM*3-1:0]      wbm_cti_i;
    logic [NM*2-1:0]      wbm_bte_i;
    logic [NM*DW-1:0]     wbm_dat_o;
    logic [NM-1:0]        wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [AW-1:0]        wbs_adr_o;
    logic [DW-1:0]        wbs_dat_o;
    logic [SW-1:0]        wbs_sel_o;
    logic                 wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]           wbs_cti_o;
    logic [1:0]           wbs_bte_o;
    logic [DW-1:0]        wbs_dat_i;
    logic                 wbs_ack_i, wbs_err_i, wbs_rty_i;
    logic [NM-1:0]        grant_o;

    always #5 wb_clk = ~wb_clk;

    peripheral_arbiter_bb #(.DW(DW), .AW(AW), .NM(NM), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .wbm_adr_i (wbm_adr_i),
        .wbm_dat_i (wbm_dat_i),
        .wbm_sel_i (wbm_sel_i),
        .wbm_we_i  (wbm_we_i),
        .wbm_cyc_i (wbm_cyc_i),
        .wbm_stb_i (wbm_stb_i),
        .wbm_cti_i (wbm_cti_i),
        .wbm_bte_i (wbm_bte_i),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_o (wbm_ack_o),
        .wbm_err_o (wbm_err_o),
        .wbm_rty_o (wbm_rty_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_cti_o (wbs_cti_o),
        .wbs_bte_o (wbs_bte_o),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_i (wbs_ack_i),
        .wbs_err_i (wbs_err_i),
        .wbs_rty_i (wbs_rty_i),
        .grant_o   (grant_o)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;

    // Reference model: who owns the bus (-1 = nobody), last winner, abort flag, stall count.
    int m_owner = -1;
    int m_last  = NM - 1;
    int m_stall = 0;
    bit m_abort = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [2:0] cti, input logic [1:0] bte);
        wbm_cyc_i[m]          = cyc;
        wbm_stb_i[m]          = stb;
        wbm_we_i[m]           = we;
        wbm_adr_i[m*AW +: AW] = adr;
        wbm_dat_i[m*DW +: DW] = dat;
        wbm_sel_i[m*SW +: SW] = SW'(m + 1);
        wbm_cti_i[m*3 +: 3]   = cti;
        wbm_bte_i[m*2 +: 2]   = bte;
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_last  = NM - 1;
        m_stall = 0;
        m_abort = 1'b0;
    endfunction

    // Advance the model by one clock using the inputs present just before the edge.
    function automatic void model_edge();
        if (m_owner < 0) begin
            if (|wbm_cyc_i) begin
                for (int i = 1; i <= NM; i++) begin
                    int k;
                    k = (m_last + i) % NM;
                    if (m_owner < 0 && wbm_cyc_i[k]) m_owner = k;
                end
                m_last  = m_owner;
                m_stall = 0;
            end
        end else if (!wbm_cyc_i[m_owner]) begin
            m_owner = -1;
            m_stall = 0;
            m_abort = 1'b0;
        end else if (!m_abort) begin
`ifdef PERIPHERAL_ARB_TIMEOUT_EN
            if (wbs_ack_i || wbs_err_i || wbs_rty_i) m_stall = 0;
            else if (wbm_stb_i[m_owner]) begin
                if (m_stall == int'(TIMEOUT) - 1) begin
                    m_abort = 1'b1;
                    m_stall = 0;
                end else m_stall++;
            end
`endif
        end
    endfunction

    task automatic check_all(input string tag);
        logic [NM-1:0]    eg, ea, ee, er;
        logic [NM*DW-1:0] edo;
        logic [AW-1:0]    eadr;
        logic [DW-1:0]    edat;
        logic [SW-1:0]    esel;
        logic [2:0]       ecti;
        logic [1:0]       ebte;
        logic             ewe, ecyc, estb, act, tmo;
        #1;
        eg = '0; ea = '0; ee = '0; er = '0; edo = '0;
        eadr = '0; edat = '0; esel = '0; ecti = '0; ebte = '0;
        ewe = 1'b0; ecyc = 1'b0; estb = 1'b0; act = 1'b0; tmo = 1'b0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            act  = !m_abort;
            eadr = wbm_adr_i[m_owner*AW +: AW];
            edat = wbm_dat_i[m_owner*DW +: DW];
            esel = wbm_sel_i[m_owner*SW +: SW];
            ecti = wbm_cti_i[m_owner*3 +: 3];
            ebte = wbm_bte_i[m_owner*2 +: 2];
            ewe  = wbm_we_i[m_owner];
            ecyc = act && wbm_cyc_i[m_owner];
            estb = ecyc && wbm_stb_i[m_owner];
`ifdef PERIPHERAL_ARB_TIMEOUT_EN
            tmo  = estb && !(wbs_ack_i || wbs_err_i || wbs_rty_i) && (m_stall == int'(TIMEOUT) - 1);
`endif
            if (act) begin
                ea[m_owner] = wbs_ack_i;
                ee[m_owner] = wbs_err_i | tmo;
                er[m_owner] = wbs_rty_i;
                edo[m_owner*DW +: DW] = wbs_dat_i;
            end
        end
        chk({tag, ".grant"}, grant_o, eg);
        chk({tag, ".scyc"}, wbs_cyc_o, ecyc);
        chk({tag, ".sstb"}, wbs_stb_o, estb);
        chk({tag, ".sadr"}, wbs_adr_o, eadr);
        chk({tag, ".sdat"}, wbs_dat_o, edat);
        chk({tag, ".ssel"}, wbs_sel_o, esel);
        chk({tag, ".swe"}, wbs_we_o, ewe);
        chk({tag, ".scti"}, wbs_cti_o, ecti);
        chk({tag, ".sbte"}, wbs_bte_o, ebte);
        chk({tag, ".mack"}, wbm_ack_o, ea);
        chk({tag, ".merr"}, wbm_err_o, ee);
        chk({tag, ".mrty"}, wbm_rty_o, er);
        chk({tag, ".mdat"}, wbm_dat_o, edo);
    endtask

    task automatic step();
        model_edge();
        @(posedge wb_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]    cti_tab [4];
        logic [NM-1:0] seq [$];
        logic [NM-1:0] exp_seq [3];
        logic [NM-1:0] g, prev;
        logic          e_err, e_cyc;

        cti_tab = '{CTI_CLASSIC, CTI_CONST, CTI_INC, CTI_EOB};
        exp_seq = '{4'b0001, 4'b0100, 4'b1000};

        wb_rst = 1'b1;
        wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = '0;
        wbm_cyc_i = '0; wbm_stb_i = '0; wbm_cti_i = '0; wbm_bte_i = '0;
        wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
        #12;
        check_all("reset");
        wb_rst = 1'b0;

        // Masters 0,2,3 request together right after reset; each does one write.
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h1111_0000, CTI_CLASSIC, 2'b00);
        set_m(2, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h2222_0000, CTI_CLASSIC, 2'b00);
        set_m(3, 1'b1, 1'b1, 1'b1, 32'h0000_0030, 32'h3333_0000, CTI_CLASSIC, 2'b00);
        prev = '0;
        for (int c = 0; c < 16; c++) begin
            int own;
            own = m_owner;
            wbs_ack_i = (own >= 0) && wbm_cyc_i[own];
            check_all("t2");
            g = grant_o;
            chk("t2.gap", 1'(prev != '0 && g != '0 && g != prev), 1'b0);
            if (g != '0 && g != prev) seq.push_back(g);
            prev = g;
            step();
            if (own >= 0 && wbs_ack_i) set_m(own, 1'b0, 1'b0, 1'b0, '0, '0, CTI_CLASSIC, 2'b00);
        end
        wbs_ack_i = 1'b0;
        chk("t2.count", seq.size(), 3);
        for (int i = 0; i < 3; i++) chk("t2.order", (i < seq.size()) ? seq[i] : '0, exp_seq[i]);

        // Master 1 single read returning 0xDEADBEEF.
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, '0, CTI_CLASSIC, 2'b00);
        check_all("t1.req");
        step();
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'hDEAD_BEEF;
        check_all("t1.ack");
        chk("t1.grant", grant_o, 4'b0010);
        chk("t1.ack_only1", wbm_ack_o, 4'b0010);
        chk("t1.rdata", wbm_dat_o[63:32], 32'hDEAD_BEEF);
        step();
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, CTI_CLASSIC, 2'b00);
        wbs_ack_i = 1'b0;
        check_all("t1.drop");
        step();
        check_all("t1.idle");
        step();

        // Master 2 4-beat incrementing burst; master 0 requests at beat 2.
        set_m(2, 1'b1, 1'b1, 1'b0, 32'h0000_0100, '0, CTI_INC, 2'b00);
        check_all("t3.req");
        step();
        for (int b = 0; b < 4; b++) begin
            set_m(2, 1'b1, 1'b1, 1'b0, AW'(32'h100 + 4 * b), '0, (b == 3) ? CTI_EOB : CTI_INC, 2'b00);
            if (b == 1) set_m(0, 1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'hA5A5_0000, CTI_CLASSIC, 2'b00);
            wbs_ack_i = 1'b1;
            wbs_dat_i = DW'(32'hB000 + b);
            check_all("t3.beat");
            chk("t3.adr", wbs_adr_o, 32'h100 + 4 * b);
            chk("t3.grant", grant_o, 4'b0100);
            step();
        end
        set_m(2, 1'b0, 1'b0, 1'b0, '0, '0, CTI_CLASSIC, 2'b00);
        wbs_ack_i = 1'b0;
        check_all("t3.drop");
        chk("t3.hold", grant_o, 4'b0100);
        step();
        check_all("t3.gap");
        chk("t3.idle", grant_o, 4'b0000);
        step();
        check_all("t3.next");
        chk("t3.m0", grant_o, 4'b0001);
        wbs_ack_i = 1'b1;
        check_all("t3.m0ack");
        step();
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, CTI_CLASSIC, 2'b00);
        wbs_ack_i = 1'b0;
        step();
        check_all("t3.end");
        step();

        // Reset pulse in beat 2 of a master 2 burst; pointer must return to NM-1.
        set_m(2, 1'b1, 1'b1, 1'b0, 32'h0000_0200, '0, CTI_INC, 2'b01);
        step();
        wbs_ack_i = 1'b1;
        check_all("t4.beat1");
        step();
        set_m(2, 1'b1, 1'b1, 1'b0, 32'h0000_0204, '0, CTI_INC, 2'b01);
        check_all("t4.beat2");
        wb_rst = 1'b1;
        #1;
        chk("t4.rst_cyc", wbs_cyc_o, 1'b0);
        chk("t4.rst_grant", grant_o, 4'b0000);
        chk("t4.rst_ack", wbm_ack_o, 4'b0000);
        model_reset();
        #1;
        wb_rst = 1'b0;
        wbs_ack_i = 1'b0;
        set_m(2, 1'b0, 1'b0, 1'b0, '0, '0, CTI_CLASSIC, 2'b00);
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0600, '0, CTI_CLASSIC, 2'b00);
        set_m(3, 1'b1, 1'b1, 1'b0, 32'h0000_0700, '0, CTI_CLASSIC, 2'b00);
        check_all("t4.req");
        step();
        check_all("t4.win");
        chk("t4.m0_first", grant_o, 4'b0001);
        wbm_cyc_i = '0;
        wbm_stb_i = '0;
        check_all("t4.drop");
        step();
        step();

        // Master 1 against a slave that never answers.
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'hC0DE_0001, CTI_CLASSIC, 2'b00);
        check_all("t5.req");
        step();
        for (int c = 1; c <= 12; c++) begin
`ifdef PERIPHERAL_ARB_TIMEOUT_EN
            e_err = (c == 8);
            e_cyc = (c <= 8);
`else
            e_err = 1'b0;
            e_cyc = 1'b1;
`endif
            check_all("t5.stall");
            chk("t5.err", wbm_err_o[1], e_err);
            chk("t5.cyc", wbs_cyc_o, e_cyc);
            chk("t5.grant", grant_o, 4'b0010);
            step();
        end
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, CTI_CLASSIC, 2'b00);
        check_all("t5.drop");
        step();
        check_all("t5.idle");
        chk("t5.released", grant_o, 4'b0000);
        step();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            int r;
            for (int m = 0; m < NM; m++) begin
                logic cyc;
                cyc = wbm_cyc_i[m];
                if ($urandom_range(0, 5) == 0) cyc = ~cyc;
                set_m(m, cyc, cyc & ($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom),
                      DW'($urandom), cti_tab[$urandom_range(0, 3)], 2'($urandom));
            end
            r = $urandom_range(0, 9);
            wbs_ack_i = (r < 5);
            wbs_err_i = (r == 5);
            wbs_rty_i = (r == 6);
            wbs_dat_i = DW'($urandom);
            check_all("rnd");
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
